// File: rtl/tracker_pkg.sv
// Shared encodings for the multi-axis tracker sequencer: drive modes, FSM states, drive directions.
package tracker_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_PARK   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_DEAD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_NEXT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_e;

endpackage

// File: rtl/axis_error_calc.sv
// Selects the active axis inputs, forms the signed error for the current mode,
// applies shortest-path wrap on rotary axes and classifies it against the deadband.
module axis_error_calc
    import tracker_pkg::*;
#(
    parameter int unsigned N_AXES    = 2,
    parameter int unsigned W         = 16,
    parameter int unsigned DEADBAND  = 5,
    parameter logic [N_AXES-1:0] WRAP_MASK = N_AXES'(1),
    parameter int unsigned FULL_TURN = 360,
    parameter int unsigned HALF_TURN = 180,
    parameter int unsigned PARK_POS  = 0,
    localparam int unsigned AW       = $clog2(N_AXES)
) (
    input  mode_e                 mode,
    input  logic [AW-1:0]         axis,
    input  logic [N_AXES*W-1:0]   sens_a,
    input  logic [N_AXES*W-1:0]   sens_b,
    input  logic [N_AXES*W-1:0]   pos_target,
    input  logic [N_AXES*W-1:0]   pos_actual,
    output logic                  balanced,
    output dir_e                  dir
);

    // Two guard bits keep the difference of two unsigned words from overflowing.
    localparam int unsigned EW = W + 2;
    localparam logic signed [EW-1:0] FULL_S = EW'(FULL_TURN);
    localparam logic signed [EW-1:0] HALF_S = EW'(HALF_TURN);
    localparam logic signed [EW-1:0] DB_S   = EW'(DEADBAND);
    localparam logic [W-1:0]         PARK_W = W'(PARK_POS);

    logic [W-1:0]           a_sel;
    logic [W-1:0]           b_sel;
    logic [W-1:0]           tgt_sel;
    logic [W-1:0]           act_sel;
    logic                   wrap_sel;
    logic signed [EW-1:0]   e_raw;
    logic signed [EW-1:0]   e_wrap;
    logic signed [EW-1:0]   e_mag;

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        tgt_sel  = '0;
        act_sel  = '0;
        wrap_sel = 1'b0;
        for (int i = 0; i < int'(N_AXES); i++) begin
            if (axis == AW'(i)) begin
                a_sel    = sens_a[i*W +: W];
                b_sel    = sens_b[i*W +: W];
                tgt_sel  = pos_target[i*W +: W];
                act_sel  = pos_actual[i*W +: W];
                wrap_sel = WRAP_MASK[i];
            end
        end
    end

    always_comb begin
        e_raw = '0;
        unique case (mode)
            MODE_AUTO:   e_raw = $signed({2'b00, b_sel})   - $signed({2'b00, a_sel});
            MODE_MANUAL: e_raw = $signed({2'b00, tgt_sel}) - $signed({2'b00, act_sel});
            MODE_PARK:   e_raw = $signed({2'b00, PARK_W})  - $signed({2'b00, act_sel});
            default:     e_raw = '0;
        endcase
    end

    // Exactly +/-HALF_TURN is left alone so a half-turn has a deterministic direction.
    always_comb begin
        e_wrap = e_raw;
        if (wrap_sel && (mode == MODE_MANUAL || mode == MODE_PARK)) begin
            if (e_raw > HALF_S) begin
                e_wrap = e_raw - FULL_S;
            end else if (e_raw < -HALF_S) begin
                e_wrap = e_raw + FULL_S;
            end
        end
    end

    always_comb begin
        e_mag    = e_wrap[EW-1] ? -e_wrap : e_wrap;
        balanced = (e_mag <= DB_S);
        if (balanced) begin
            dir = DIR_NONE;
        end else if (e_wrap[EW-1]) begin
            dir = DIR_POS;
        end else begin
            dir = DIR_NEG;
        end
    end

endmodule

// File: rtl/tracker_axis_sequencer.sv
// Round-robin multi-axis motor sequencer with reversal dead time, settle time,
// per-visit drive timeout and sticky per-axis fault flags.
module tracker_axis_sequencer
    import tracker_pkg::*;
#(
    parameter int unsigned N_AXES         = 2,
    parameter int unsigned W              = 16,
    parameter int unsigned DEADBAND       = 5,
    parameter logic [N_AXES-1:0] WRAP_MASK = N_AXES'(1),
    parameter int unsigned FULL_TURN      = 360,
    parameter int unsigned HALF_TURN      = 180,
    parameter int unsigned PARK_POS       = 0,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned AW            = $clog2(N_AXES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [N_AXES*W-1:0]   sens_a,
    input  logic [N_AXES*W-1:0]   sens_b,
    input  logic [N_AXES*W-1:0]   pos_target,
    input  logic [N_AXES*W-1:0]   pos_actual,
    output logic [N_AXES-1:0]     out_pos,
    output logic [N_AXES-1:0]     out_neg,
    output logic [AW-1:0]         active_axis,
    output logic                  busy,
    output logic [N_AXES-1:0]     fault
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PMAX = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW   = $clog2(PMAX + 1);

    state_e             state;
    mode_e              mode_in;
    mode_e              mode_q;
    logic [TW-1:0]      drv_cnt;
    logic [PW-1:0]      tmr;
    dir_e               last_dir [N_AXES];
    logic               balanced;
    dir_e               dir;
    logic [N_AXES-1:0]  sel_c;

    assign mode_in = mode_e'(mode);
    assign sel_c   = N_AXES'(1) << active_axis;

    axis_error_calc #(
        .N_AXES    (N_AXES),
        .W         (W),
        .DEADBAND  (DEADBAND),
        .WRAP_MASK (WRAP_MASK),
        .FULL_TURN (FULL_TURN),
        .HALF_TURN (HALF_TURN),
        .PARK_POS  (PARK_POS)
    ) u_err (
        .mode       (mode_in),
        .axis       (active_axis),
        .sens_a     (sens_a),
        .sens_b     (sens_b),
        .pos_target (pos_target),
        .pos_actual (pos_actual),
        .balanced   (balanced),
        .dir        (dir)
    );

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_HOLD;
            active_axis <= '0;
            out_pos     <= '0;
            out_neg     <= '0;
            busy        <= 1'b0;
            fault       <= '0;
            drv_cnt     <= '0;
            tmr         <= '0;
            for (int i = 0; i < int'(N_AXES); i++) begin
                last_dir[i] <= DIR_NONE;
            end
        end else begin
            if (mode_in == MODE_HOLD) begin
                fault <= '0;
            end

            if (state != ST_IDLE && mode_in != mode_q) begin
                state   <= ST_IDLE;
                out_pos <= '0;
                out_neg <= '0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        out_pos <= '0;
                        out_neg <= '0;
                        if (mode_in != MODE_HOLD) begin
                            state       <= ST_EVAL;
                            mode_q      <= mode_in;
                            active_axis <= '0;
                            busy        <= 1'b1;
                        end
                    end

                    ST_EVAL: begin
                        drv_cnt <= '0;
                        tmr     <= '0;
                        if (fault[active_axis] || balanced) begin
                            state <= ST_NEXT;
                        end else if (last_dir[active_axis] != DIR_NONE &&
                                     last_dir[active_axis] != dir) begin
                            state <= ST_DEAD;
                        end else begin
                            state                 <= ST_DRIVE;
                            out_pos               <= (dir == DIR_POS) ? sel_c : '0;
                            out_neg               <= (dir == DIR_NEG) ? sel_c : '0;
                            last_dir[active_axis] <= dir;
                            drv_cnt               <= TW'(1);
                        end
                    end

                    ST_DRIVE: begin
                        if (balanced) begin
                            state   <= ST_SETTLE;
                            out_pos <= '0;
                            out_neg <= '0;
                            tmr     <= '0;
                        end else if (dir != last_dir[active_axis]) begin
                            state   <= ST_DEAD;
                            out_pos <= '0;
                            out_neg <= '0;
                            tmr     <= '0;
                        end else if (drv_cnt >= TW'(TIMEOUT_CYCLES)) begin
                            state              <= ST_NEXT;
                            out_pos            <= '0;
                            out_neg            <= '0;
                            fault[active_axis] <= 1'b1;
                        end else begin
                            drv_cnt <= drv_cnt + TW'(1);
                        end
                    end

                    // Direction is re-sampled at the end of dead time, not remembered from entry.
                    ST_DEAD: begin
                        if (tmr == PW'(DEAD_CYCLES - 1)) begin
                            tmr <= '0;
                            if (balanced) begin
                                state <= ST_SETTLE;
                            end else begin
                                state                 <= ST_DRIVE;
                                out_pos               <= (dir == DIR_POS) ? sel_c : '0;
                                out_neg               <= (dir == DIR_NEG) ? sel_c : '0;
                                last_dir[active_axis] <= dir;
                                drv_cnt               <= drv_cnt + TW'(1);
                            end
                        end else begin
                            tmr <= tmr + PW'(1);
                        end
                    end

                    ST_SETTLE: begin
                        if (tmr == PW'(SETTLE_CYCLES - 1)) begin
                            state <= ST_NEXT;
                            tmr   <= '0;
                        end else begin
                            tmr <= tmr + PW'(1);
                        end
                    end

                    ST_NEXT: begin
                        state       <= ST_EVAL;
                        active_axis <= (active_axis == AW'(N_AXES - 1)) ? '0
                                                                       : active_axis + AW'(1);
                    end

                    default: begin
                        state   <= ST_IDLE;
                        out_pos <= '0;
                        out_neg <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tracker_axis_sequencer.sv
// Directed bench for tracker_axis_sequencer: two axes, axis 0 rotary, short timeout.
module tb_tracker_axis_sequencer;

    localparam int unsigned N_AXES = 2;
    localparam int unsigned W      = 16;

    logic                 clk;
    logic                 rst;
    logic [1:0]           mode;
    logic [N_AXES*W-1:0]  sens_a;
    logic [N_AXES*W-1:0]  sens_b;
    logic [N_AXES*W-1:0]  pos_target;
    logic [N_AXES*W-1:0]  pos_actual;
    logic [N_AXES-1:0]    out_pos;
    logic [N_AXES-1:0]    out_neg;
    logic                 active_axis;
    logic                 busy;
    logic [N_AXES-1:0]    fault;

    int n_vec = 0;
    int n_err = 0;
    int drv_cycles;

    tracker_axis_sequencer #(
        .N_AXES         (N_AXES),
        .W              (W),
        .WRAP_MASK      (2'b01),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .sens_a      (sens_a),
        .sens_b      (sens_b),
        .pos_target  (pos_target),
        .pos_actual  (pos_actual),
        .out_pos     (out_pos),
        .out_neg     (out_neg),
        .active_axis (active_axis),
        .busy        (busy),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset with random inputs and an active mode
        rst        = 1'b0;
        mode       = 2'b11;
        sens_a     = $urandom;
        sens_b     = $urandom;
        pos_target = $urandom;
        pos_actual = $urandom;
        repeat (3) tick();
        check("rst_pos",   32'(out_pos),     32'd0);
        check("rst_neg",   32'(out_neg),     32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_axis",  32'(active_axis), 32'd0);
        check("rst_fault", 32'(fault),       32'd0);

        mode       = 2'b00;
        sens_a     = '0;
        sens_b     = '0;
        pos_target = '0;
        pos_actual = '0;
        rst        = 1'b1;
        repeat (3) tick();
        check("idle_busy", 32'(busy),    32'd0);
        check("idle_pos",  32'(out_pos), 32'd0);

        // Manual: axis0 on target, axis1 actual 120 > target 100 drives pos
        pos_target = {16'd100, 16'd50};
        pos_actual = {16'd120, 16'd50};
        mode       = 2'b01;
        tick();
        check("t2_busy",    32'(busy),        32'd1);
        check("t2_eval_ax", 32'(active_axis), 32'd0);
        tick();
        tick();
        check("t2_ax1",     32'(active_axis), 32'd1);
        check("t2_pre_off", 32'({out_pos, out_neg}), 32'd0);
        tick();
        check("t2_drive_pos", 32'(out_pos), 32'h2);
        check("t2_drive_neg", 32'(out_neg), 32'h0);
        repeat (3) tick();
        check("t2_hold_pos", 32'(out_pos), 32'h2);
        pos_actual = {16'd105, 16'd50};
        tick();
        check("t2_settle_off", 32'({out_pos, out_neg}), 32'd0);
        repeat (7) tick();
        check("t2_settle_ax",   32'(active_axis), 32'd1);
        check("t2_settle_busy", 32'(busy),        32'd1);
        tick();
        tick();
        check("t2_next_ax", 32'(active_axis), 32'd0);
        mode = 2'b00;
        tick();
        check("t2_idle", 32'(busy), 32'd0);

        // Manual wrap: 350 vs 10 wraps to -20 (pos); 190 vs 10 is +180 exactly (neg)
        pos_target = {16'd105, 16'd350};
        pos_actual = {16'd105, 16'd10};
        mode       = 2'b01;
        tick();
        check("t3_lat1", 32'(out_pos), 32'd0);
        tick();
        check("t3_wrap_pos", 32'(out_pos), 32'h1);
        pos_target = {16'd105, 16'd190};
        tick();
        check("t3_dead0", 32'({out_pos, out_neg}), 32'd0);
        repeat (3) begin
            tick();
            check("t3_dead", 32'({out_pos, out_neg}), 32'd0);
        end
        tick();
        check("t3_half_neg", 32'(out_neg), 32'h1);
        check("t3_half_pos", 32'(out_pos), 32'h0);
        mode = 2'b00;
        tick();

        // Auto: last direction of axis0 is neg, so pos demand waits out dead time first
        sens_a = {16'd300, 16'd500};
        sens_b = {16'd300, 16'd400};
        mode   = 2'b10;
        repeat (5) tick();
        check("t4_xmode_dead", 32'({out_pos, out_neg}), 32'd0);
        tick();
        check("t4_auto_pos", 32'(out_pos), 32'h1);
        sens_a = {16'd300, 16'd400};
        sens_b = {16'd300, 16'd500};
        repeat (4) begin
            tick();
            check("t4_dead", 32'({out_pos, out_neg}), 32'd0);
        end
        tick();
        check("t4_auto_neg", 32'(out_neg), 32'h1);
        check("t4_auto_pos_off", 32'(out_pos), 32'h0);
        mode = 2'b00;
        tick();

        // Deadband edge: e = 5 is balanced, e = 6 drives neg
        sens_a = {16'd300, 16'd0};
        sens_b = {16'd300, 16'd5};
        mode   = 2'b10;
        repeat (3) tick();
        check("t5_db_skip", 32'(active_axis), 32'd1);
        check("t5_db_off",  32'({out_pos, out_neg}), 32'd0);
        repeat (3) tick();
        check("t5_db_off2", 32'({out_pos, out_neg}), 32'd0);
        mode = 2'b00;
        tick();
        sens_b = {16'd300, 16'd6};
        mode   = 2'b10;
        tick();
        tick();
        check("t5_db_neg", 32'(out_neg), 32'h1);
        mode = 2'b00;
        tick();

        // Timeout: axis0 never reaches target, drives exactly 20 cycles then faults
        pos_target = {16'd105, 16'd100};
        pos_actual = {16'd105, 16'd50};
        mode       = 2'b01;
        drv_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_neg[0]) drv_cycles++;
        end
        check("t6_drive_len", 32'(drv_cycles), 32'd20);
        check("t6_fault",     32'(fault),      32'h1);
        check("t6_off",       32'({out_pos, out_neg}), 32'd0);
        check("t6_busy",      32'(busy),       32'd1);
        mode = 2'b00;
        tick();
        check("t6_fault_clr", 32'(fault), 32'h0);
        check("t6_idle",      32'(busy),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tracker_axis_sequencer.md
Name: tracker_axis_sequencer

Overview:
Parametrised multi-axis successor to the two-axis tracker motor controller. Drives N_AXES motors one at a time, round-robin. Three drive modes:
- Automatic: balances a photoresistor pair per axis.
- Manual: seeks a commanded position, with shortest-path wrap on rotating axes.
- Park: seeks a fixed park position.

Adds what the two-axis controller lacks: direction-reversal dead time, post-move settle time, per-axis drive timeout with fault flags, and overflow-safe signed error arithmetic. Sits between the sensor/position front end and the motor H-bridge drivers.

Parameters:
N_AXES, 2, number of motor axes (2..8)
W, 16, width of each sensor/position word
DEADBAND, 5, error magnitude treated as balanced/on-target (inclusive)
WRAP_MASK, 2'b01, bit i set = axis i is rotary and uses shortest-path wrap
FULL_TURN, 360, position units per revolution (wrap axes)
HALF_TURN, 180, shortest-path threshold
PARK_POS, 0, park target for every axis
DEAD_CYCLES, 4, outputs-off cycles before any direction reversal
SETTLE_CYCLES, 8, outputs-off cycles after an axis reaches target
TIMEOUT_CYCLES, 1000000, max continuous drive cycles per axis visit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
mode  in  2  00 hold, 01 manual, 10 automatic, 11 park
sens_a  in  N_AXES*W  sensor A per axis, axis i at [i*W +: W], unsigned
sens_b  in  N_AXES*W  sensor B per axis, unsigned
pos_target  in  N_AXES*W  manual target per axis, unsigned
pos_actual  in  N_AXES*W  measured position per axis, unsigned
out_pos  out  N_AXES  drive positive (clockwise) per axis
out_neg  out  N_AXES  drive negative (counter-clockwise) per axis
active_axis  out  clog2(N_AXES)  axis currently being served
busy  out  1  high in any state other than IDLE
fault  out  N_AXES  sticky per-axis timeout flag

Behaviour:
- Reset (rst=0, async): all outputs 0, active_axis 0, FSM IDLE, all counters 0, last-direction memory cleared.
- All outputs are registered. out_pos[i] and out_neg[i] are never both 1. Only the active axis may be driven.
- Error per axis, computed in W+2-bit signed arithmetic (no underflow):
  - auto: e = sens_b - sens_a
  - manual: e = pos_target - pos_actual
  - park: e = PARK_POS - pos_actual
- Wrap (manual/park, WRAP_MASK[i]=1): if e > HALF_TURN then e -= FULL_TURN; if e < -HALF_TURN then e += FULL_TURN. e = ±HALF_TURN exactly is left unchanged.
- Balanced when |e| <= DEADBAND. Otherwise direction is pos when e < 0, neg when e > 0. This matches the prior convention: actual > target drives pos, sens_a > sens_b drives pos.
- FSM states and transitions:
  - IDLE: outputs off. Leaves to EVAL when mode != 00, with active_axis = 0.
  - EVAL (1 cycle):
    - axis faulted or balanced -> NEXT
    - required direction opposite to that axis's last driven direction -> DEAD
    - otherwise -> DRIVE, with the output asserted from the edge leaving EVAL
    - Latency from mode leaving 00 to first drive = 2 clk edges.
  - DRIVE: re-evaluates error every cycle.
    - balanced -> SETTLE (outputs off the next edge)
    - direction flip -> DEAD (outputs off)
    - drive counter reaches TIMEOUT_CYCLES -> set fault[axis], outputs off, NEXT
  - DEAD: outputs off for DEAD_CYCLES, then DRIVE in the freshly evaluated direction.
  - SETTLE: outputs off for SETTLE_CYCLES, then NEXT.
  - NEXT (1 cycle): active_axis = (active_axis+1) mod N_AXES, then EVAL. Wrap from N_AXES-1 to 0.
- Mode change in any state other than IDLE: outputs off on the next edge, return to IDLE. The new mode restarts at axis 0 through IDLE.
- Faults:
  - Cleared only by reset or by mode = 00.
  - If every axis is faulted, the FSM cycles EVAL/NEXT with outputs off.
- The last-direction memory survives mode changes, so dead time is enforced across modes.

Decomposition:
- Shared package tracker_pkg: mode encodings, the FSM state enum, direction enum (NONE/POS/NEG).
- One natural sub-module, axis_error_calc: combinational mux of the active axis's inputs, signed subtraction, wrap, deadband compare. Outputs balanced and dir.

Test Plan:
1. Reset held, inputs random -> all outputs 0, busy 0. Release with mode=00 -> stays IDLE.
2. Manual, axis1 non-wrap, target 100, actual 120 -> out_pos[1] after axis0 settles. Ramp actual down to 105 -> drive off, SETTLE 8 cycles, active_axis advances.
3. Manual, wrap axis0, target 350, actual 10 -> e = -20 after wrap -> out_pos[0]. Target 190, actual 10 -> e = +180 -> out_neg[0].
4. Auto, axis0 sens_a=500 sens_b=400 -> out_pos[0]. Swap mid-drive -> 4 cycles both off, then out_neg[0].
5. DEADBAND boundary: sens_a=0, sens_b=5 -> balanced, no drive (no underflow). sens_b=6 -> out_neg.
6. TIMEOUT_CYCLES=20, target never reached -> drive exactly 20 cycles, fault[i]=1, axis skipped thereafter. mode=00 clears fault.
